elbeth_mult_div: RTL and testbench

Iterative RV32M multiply/divide unit for the ELBETH execute stage. It accepts one operation at a time, computes it over 32 cycles of shift-add (multiply) or restoring division, and presents a registered 32-bit result. That result feeds the execute-stage 32-bit 2-to-1 result select alongside the ALU output. The pipeline stalls on `md_busy` and captures `md_result` on `md_done`.

---
 rtl/elbeth_mult_div_pkg.sv | 28 ++
 rtl/elbeth_md_datapath.sv | 51 +++++
 rtl/elbeth_mult_div.sv | 140 ++++++++++++++
 tb/tb_elbeth_mult_div.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/elbeth_mult_div_pkg.sv
// Shared encodings, constants and helpers for the ELBETH iterative multiply/divide unit.
package elbeth_mult_div_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } md_state_e;

    localparam logic [31:0] MD_MIN_NEG  = 32'h8000_0000;
    localparam logic [31:0] MD_ALL_ONES = 32'hFFFF_FFFF;

    function automatic logic [31:0] md_cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/elbeth_md_datapath.sv
// One shift-add / restoring-divide iteration step plus the final sign correction
// applied to the value produced by that step.
module elbeth_md_datapath
    import elbeth_mult_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  md_op_e              op_i,
    input  logic                neg_i,
    input  logic [2*XLEN-1:0]   acc_i,
    input  logic [XLEN-1:0]     x_i,
    input  logic [XLEN-1:0]     y_i,
    output logic [2*XLEN-1:0]   acc_nxt_o,
    output logic [XLEN-1:0]     x_nxt_o,
    output logic [XLEN-1:0]     result_o
);

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     trial;
    logic [XLEN+1:0]   diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_new;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        mul_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, (x_i[0] ? y_i : {XLEN{1'b0}})};
        // Division: acc high half is the partial remainder, x shifts the dividend in MSB-first.
        trial   = {acc_i[2*XLEN-1:XLEN], x_i[XLEN-1]};
        diff    = {1'b0, trial} - {2'b00, y_i};
        q_bit   = ~diff[XLEN+1];
        rem_new = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];

        if (op_i[2]) begin
            acc_nxt_o = {rem_new, acc_i[XLEN-2:0], q_bit};
            x_nxt_o   = x_i << 1;
        end else begin
            acc_nxt_o = {mul_sum, acc_i[XLEN-1:1]};
            x_nxt_o   = x_i >> 1;
        end

        prod = neg_i ? (~acc_nxt_o + (2*XLEN)'(1)) : acc_nxt_o;

        case (op_i)
            MD_MUL:                       result_o = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              result_o = md_cond_neg(acc_nxt_o[XLEN-1:0], neg_i);
            default:                      result_o = md_cond_neg(acc_nxt_o[2*XLEN-1:XLEN], neg_i);
        endcase
    end

endmodule

// File: rtl/elbeth_mult_div.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply or restoring divide on
// operand magnitudes, with division special cases resolved in a single cycle.
module elbeth_mult_div
    import elbeth_mult_div_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            md_start,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] md_operand_a,
    input  logic [XLEN-1:0] md_operand_b,
    input  logic            md_kill,
    output logic            md_busy,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    localparam int CNT_W = $clog2(ITER);

    md_state_e         state_q, state_d;
    md_op_e            op_q, op_d, op_in;
    logic [XLEN-1:0]   x_q, x_d, y_q, y_d, result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d, dp_acc_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   dp_x_nxt, dp_result;

    logic              a_signed, b_signed, sign_a, sign_b, neg_in;
    logic              div_zero, div_ovf, special, launch;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;

    always_comb begin
        op_in    = md_op_e'(md_op);
        a_signed = (op_in == MD_MUL) || (op_in == MD_MULH) || (op_in == MD_MULHSU) ||
                   (op_in == MD_DIV) || (op_in == MD_REM);
        b_signed = (op_in == MD_MUL) || (op_in == MD_MULH) ||
                   (op_in == MD_DIV) || (op_in == MD_REM);
        sign_a   = a_signed & md_operand_a[XLEN-1];
        sign_b   = b_signed & md_operand_b[XLEN-1];
        mag_a    = md_cond_neg(md_operand_a, sign_a);
        mag_b    = md_cond_neg(md_operand_b, sign_b);
        // Remainder takes the dividend's sign; everything else the product/quotient sign.
        neg_in   = (op_in == MD_REM || op_in == MD_REMU) ? sign_a : (sign_a ^ sign_b);

        div_zero = op_in[2] && (md_operand_b == '0);
        div_ovf  = (op_in == MD_DIV || op_in == MD_REM) &&
                   (md_operand_a == MD_MIN_NEG) && (md_operand_b == MD_ALL_ONES);
        special  = div_zero || div_ovf;
        if (div_zero) special_res = op_in[1] ? md_operand_a : MD_ALL_ONES;
        else          special_res = op_in[1] ? '0 : MD_MIN_NEG;

        launch   = md_start && !md_kill && (state_q != ST_CALC);
    end

    elbeth_md_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .op_i      (op_q),
        .neg_i     (neg_q),
        .acc_i     (acc_q),
        .x_i       (x_q),
        .y_i       (y_q),
        .acc_nxt_o (dp_acc_nxt),
        .x_nxt_o   (dp_x_nxt),
        .result_o  (dp_result)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;

        case (state_q)
            ST_CALC: begin
                acc_d = dp_acc_nxt;
                x_d   = dp_x_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d  = ST_FINISH;
                    result_d = dp_result;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (launch && special) begin
                    state_d  = ST_FINISH;
                    result_d = special_res;
                end else if (launch) begin
                    state_d = ST_CALC;
                    op_d    = op_in;
                    neg_d   = neg_in;
                    x_d     = op_in[2] ? mag_a : mag_b;
                    y_d     = op_in[2] ? mag_b : mag_a;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
        endcase

        if (md_kill) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= MD_MUL;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign md_busy   = (state_q == ST_CALC);
    assign md_done   = (state_q == ST_FINISH);
    assign md_result = result_q;

endmodule

// File: tb/tb_elbeth_mult_div.sv
// Scoreboard bench for elbeth_mult_div: stimulus pushes reference results, a negedge
// monitor pops and compares on every md_done.
module tb_elbeth_mult_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        md_start = 1'b0;
    logic        md_kill = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] opa = 32'd0;
    logic [31:0] opb = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    elbeth_mult_div dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .md_start     (md_start),
        .md_op        (md_op),
        .md_operand_a (opa),
        .md_operand_b (opb),
        .md_kill      (md_kill),
        .md_busy      (busy),
        .md_done      (done),
        .md_result    (result)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference: 64-bit integer arithmetic following the RV32M rules.
    function automatic logic [31:0] ref_md(input int op, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        uy = longint'({32'h0, y});
        p  = 64'd0;
        case (op)
            0: begin p = sx * sy; return p[31:0]; end
            1: begin p = sx * sy; return p[63:32]; end
            2: begin p = sx * uy; return p[63:32]; end
            3: begin p = {32'h0, x} * {32'h0, y}; return p[63:32]; end
            4: begin if (y == 0) return 32'hFFFF_FFFF; p = sx / sy; return p[31:0]; end
            5: begin if (y == 0) return 32'hFFFF_FFFF; return x / y; end
            6: begin if (y == 0) return x; p = sx % sy; return p[31:0]; end
            default: begin if (y == 0) return x; return x % y; end
        endcase
    endfunction

    function automatic bit is_special(input int op, input logic [31:0] x, input logic [31:0] y);
        return (op >= 4) && ((y == 0) ||
               ((op == 4 || op == 6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    task automatic start_op(input int op, input logic [31:0] x, input logic [31:0] y, input bit expect_done);
        md_op    = 3'(op);
        opa      = x;
        opb      = y;
        md_start = 1'b1;
        if (expect_done) sb.push_back(ref_md(op, x, y));
        @(negedge clk);
        md_start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc, output int nbusy);
        cyc   = c0;
        nbusy = 0;
        while (!done && cyc < 80) begin
            if (busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input int op, input logic [31:0] x, input logic [31:0] y);
        int cyc, nb;
        bit sp;
        sp = is_special(op, x, y);
        start_op(op, x, y, 1'b1);
        wait_done(1, cyc, nb);
        chk("latency", cyc, sp ? 1 : 33);
        chk("busy_cycles", nb, sp ? 0 : 32);
        chk("busy_at_done", busy, 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: result 0x%0h, required no completion", result);
            end else begin
                chk("result", result, sb.pop_front());
            end
        end
    end

    initial begin
        int          cyc, nb, op, sel;
        logic [31:0] held, x, y;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 32'd7, 32'd6);
        run_op(1, 32'h8000_0000, 32'h8000_0000);
        run_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2, 32'hFFFF_FFFF, 32'd2);
        run_op(4, 32'hFFFF_FFF9, 32'd2);
        run_op(6, 32'hFFFF_FFF9, 32'd2);
        run_op(5, 32'd100, 32'd7);
        run_op(7, 32'd100, 32'd7);
        run_op(5, 32'd5, 32'd0);
        run_op(6, 32'd5, 32'd0);
        run_op(4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(6, 32'h8000_0000, 32'hFFFF_FFFF);

        // back-to-back: normal, then special and normal launched in done cycles
        start_op(1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        wait_done(1, cyc, nb);
        chk("b2b_first_lat", cyc, 33);
        start_op(4, 32'd5, 32'd0, 1'b1);
        wait_done(1, cyc, nb);
        chk("b2b_special_lat", cyc, 1);
        start_op(0, 32'hFFFF_FFFD, 32'd3, 1'b1);
        wait_done(1, cyc, nb);
        chk("b2b_second_lat", cyc, 33);
        @(negedge clk);

        // kill in cycle 10
        held = result;
        start_op(0, 32'd123, 32'd456, 1'b0);
        repeat (9) @(negedge clk);
        md_kill = 1'b1;
        @(negedge clk);
        md_kill = 1'b0;
        chk("kill_busy", busy, 0);
        repeat (40) @(negedge clk);
        chk("kill_result_held", result, held);

        // kill beats a simultaneous start
        md_op = 3'd5; opa = 32'd9; opb = 32'd0; md_start = 1'b1; md_kill = 1'b1;
        @(negedge clk);
        md_start = 1'b0; md_kill = 1'b0;
        chk("kill_start_busy", busy, 0);
        chk("kill_start_done", done, 0);
        @(negedge clk);

        // start while busy is ignored
        start_op(5, 32'd1000, 32'd3, 1'b1);
        repeat (4) @(negedge clk);
        md_op = 3'd0; opa = 32'd9; opb = 32'd9; md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        wait_done(6, cyc, nb);
        chk("ignored_start_lat", cyc, 33);
        repeat (3) @(negedge clk);

        // asynchronous reset in cycle 20
        start_op(0, 32'd3, 32'd5, 1'b0);
        repeat (19) @(negedge clk);
        chk("arst_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            op  = $urandom_range(0, 7);
            x   = $urandom;
            y   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) y = 32'd0;
            if (sel == 1) y = $urandom_range(1, 15);
            if (sel == 2) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            if (sel == 3) x = $urandom_range(0, 100);
            run_op(op, x, y);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
